// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and helpers for the round-robin FIFO write arbiter.
package fifo_arb_pkg;

   typedef enum logic [0:0] {
      ARB_IDLE  = 1'b0,
      ARB_GRANT = 1'b1
   } arb_state_e;

   // The search helper works on a fixed-width vector; NUM_REQ must not exceed it.
   localparam int RR_MAX_REQ = 32;
   localparam int RR_ID_W    = 5;

   typedef struct packed {
      logic               found;
      logic [RR_ID_W-1:0] id;
   } rr_result_t;

   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic rr_result_t rr_next(input logic [RR_MAX_REQ-1:0] valid,
                                          input int n,
                                          input int last_id);
      rr_result_t res;
      int         idx;
      res = '0;
      idx = 0;
      for (int k = 1; k <= RR_MAX_REQ; k++) begin
         if ((k <= n) && !res.found) begin
            idx = (last_id + k) % n;
            if (valid[RR_ID_W'(idx)]) begin
               res.found = 1'b1;
               res.id    = RR_ID_W'(idx);
            end else begin
               res.found = 1'b0;
            end
         end else begin
            res = res;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer handshake plus FIFO write-port bundle shared by the arbiter and its environment.
interface fifo_wr_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 32,
   parameter int ID_W       = fifo_arb_pkg::id_width(NUM_REQ)
);

   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            req_ready;
   logic                          fifo_full;
   logic                          fifo_cs;
   logic                          fifo_wr_en;
   logic [DATA_WIDTH-1:0]         fifo_data;
   logic [ID_W-1:0]               grant_id;
   logic                          busy;

   modport master (
      input  req_valid, req_data, fifo_full,
      output req_ready, fifo_cs, fifo_wr_en, fifo_data, grant_id, busy
   );

   modport slave (
      output req_valid, req_data, fifo_full,
      input  req_ready, fifo_cs, fifo_wr_en, fifo_data, grant_id, busy
   );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin pick: rotate so the search starts after last_id,
// priority-encode the lowest set bit, then rotate the index back.
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = id_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_valid,
   input  logic [ID_W-1:0]    i_last_id,
   output logic               o_found,
   output logic [ID_W-1:0]    o_id
);

   int                 w_start;
   int                 w_win;
   logic [NUM_REQ-1:0] w_rot;
   rr_result_t         w_enc;

   // Rotate, encode and un-rotate in one pass.
   always_comb begin
      w_start = (int'(i_last_id) >= NUM_REQ - 1) ? 0 : int'(i_last_id) + 1;
      w_rot   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_rot[k] = i_valid[ID_W'((w_start + k) % NUM_REQ)];
      end
      // Searching "after NUM_REQ-1" is a plain lowest-index priority encode.
      w_enc   = rr_next(RR_MAX_REQ'(w_rot), NUM_REQ, NUM_REQ - 1);
      w_win   = (w_start + int'(w_enc.id)) % NUM_REQ;
      o_found = w_enc.found;
      o_id    = ID_W'(w_win);
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one synchronous FIFO write port among NUM_REQ
// valid/ready producers, holding each grant for up to MAX_BURST beats.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 32,
   parameter int MAX_BURST  = 4
) (
   input logic               i_clk,
   input logic               i_rst_n,
   fifo_wr_arbiter_if.master bus
);

   localparam int                ID_W        = id_width(NUM_REQ);
   localparam int                CNT_W       = $clog2(MAX_BURST + 1);
   localparam logic [ID_W-1:0]   LAST_ID_RST = ID_W'(NUM_REQ - 1);
   localparam logic [CNT_W-1:0]  LAST_BEAT   = CNT_W'(MAX_BURST - 1);

   arb_state_e            r_state;
   logic [ID_W-1:0]       r_grant_id;
   logic [ID_W-1:0]       r_last_id;
   logic [CNT_W-1:0]      r_beat_cnt;

   logic                  w_found;
   logic [ID_W-1:0]       w_winner;
   logic                  w_grant;
   logic                  w_g_valid;
   logic                  w_xfer;
   logic                  w_release;
   logic [NUM_REQ-1:0]    w_ready;
   logic [DATA_WIDTH-1:0] w_data;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_rr_pick (
      .i_valid   (bus.req_valid),
      .i_last_id (r_last_id),
      .o_found   (w_found),
      .o_id      (w_winner)
   );

   // Reset is gated in so a reset cycle mid-burst never writes the FIFO.
   assign w_grant   = (r_state == ARB_GRANT) & i_rst_n;
   assign w_g_valid = bus.req_valid[r_grant_id];
   assign w_xfer    = w_grant & w_g_valid & ~bus.fifo_full;
   assign w_release = ~w_g_valid | (w_xfer & (r_beat_cnt == LAST_BEAT));

   // Grantee ready and write-data mux.
   always_comb begin
      w_ready = '0;
      w_data  = '0;
      if (w_grant) begin
         w_ready[r_grant_id] = ~bus.fifo_full;
         w_data              = bus.req_data[int'(r_grant_id) * DATA_WIDTH +: DATA_WIDTH];
      end else begin
         w_ready = '0;
         w_data  = '0;
      end
   end

   assign bus.req_ready  = w_ready;
   assign bus.fifo_wr_en = w_xfer;
   assign bus.fifo_cs    = w_xfer;
   assign bus.fifo_data  = w_data;
   assign bus.grant_id   = r_grant_id;
   assign bus.busy       = (r_state == ARB_GRANT);

   // Arbitration state machine with synchronous reset.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state    <= ARB_IDLE;
         r_grant_id <= '0;
         r_last_id  <= LAST_ID_RST;
         r_beat_cnt <= '0;
      end else begin
         case (r_state)
            ARB_IDLE: begin
               if (w_found) begin
                  r_state    <= ARB_GRANT;
                  r_grant_id <= w_winner;
                  r_beat_cnt <= '0;
               end else begin
                  r_state <= ARB_IDLE;
               end
            end
            ARB_GRANT: begin
               if (w_release) begin
                  r_state    <= ARB_IDLE;
                  r_last_id  <= r_grant_id;
                  r_beat_cnt <= '0;
               end else if (w_xfer) begin
                  r_beat_cnt <= r_beat_cnt + CNT_W'(1);
               end else begin
                  r_beat_cnt <= r_beat_cnt;
               end
            end
            default: begin
               r_state    <= ARB_IDLE;
               r_beat_cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: vector table plus hand-written corner sequences.
module tb_fifo_wr_arbiter;

   localparam int NR = 4;
   localparam int DW = 32;
   localparam int MB = 4;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) u_if ();

   fifo_wr_arbiter #(
      .NUM_REQ    (NR),
      .DATA_WIDTH (DW),
      .MAX_BURST  (MB)
   ) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (u_if)
   );

   typedef struct {
      logic        rst_n;
      logic [3:0]  valid;
      logic        full;
      logic [3:0]  ready;
      logic        wr;
      logic        busy;
      bit          ck_busy;
      logic [1:0]  gid;
      logic [31:0] data;
   } vec_t;

   vec_t       vecs[$];
   int         n_pass  = 0;
   int         n_total = 0;
   int         seq[NR];
   logic [3:0] hs;

   function automatic logic [31:0] word(input int p, input int s);
      return {12'hA00, 4'(p), 16'(s)};
   endfunction

   function automatic vec_t vr(input logic [3:0] valid, input bit ck_busy);
      vec_t v;
      v.rst_n = 1'b0; v.valid = valid; v.full = 1'b0; v.ready = 4'b0000;
      v.wr = 1'b0; v.busy = 1'b0; v.ck_busy = ck_busy; v.gid = 2'd0; v.data = 32'h0;
      return v;
   endfunction

   function automatic vec_t vn(input logic [3:0] valid, input logic full, input logic [3:0] ready,
                               input logic wr, input logic busy, input logic [1:0] gid,
                               input logic [31:0] data);
      vec_t v;
      v.rst_n = 1'b1; v.valid = valid; v.full = full; v.ready = ready;
      v.wr = wr; v.busy = busy; v.ck_busy = 1'b1; v.gid = gid; v.data = data;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
      else n_pass++;
   endtask

   // Drive one cycle's inputs; producer i offers word(i, seq[i]).
   task automatic apply(input logic rst, input logic [3:0] valid, input logic full);
      if (!rst) for (int i = 0; i < NR; i++) seq[i] = 0;
      rst_n          = rst;
      u_if.req_valid = valid;
      u_if.fifo_full = full;
      for (int i = 0; i < NR; i++) u_if.req_data[i*DW +: DW] = word(i, seq[i]);
      #1;
   endtask

   task automatic advance();
      hs = u_if.req_ready & u_if.req_valid;
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) if (hs[i]) seq[i]++;
   endtask

   logic [13:0] pat;
   int          nexp;

   initial begin
      rst_n          = 1'b0;
      u_if.req_valid = '0;
      u_if.req_data  = '0;
      u_if.fifo_full = 1'b0;

      // Reset with all valid, then round robin 0,1,2,3,0 with 4-beat bursts.
      vecs.push_back(vr(4'hF, 1'b0));
      vecs.push_back(vr(4'hF, 1'b1));
      for (int g = 0; g < NR; g++) begin
         vecs.push_back(vn(4'hF, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 32'h0));
         for (int k = 0; k < MB; k++)
            vecs.push_back(vn(4'hF, 1'b0, 4'(4'b0001 << g), 1'b1, 1'b1, 2'(g), word(g, k)));
      end
      vecs.push_back(vn(4'hF, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 32'h0));
      vecs.push_back(vn(4'hF, 1'b0, 4'b0001, 1'b1, 1'b1, 2'd0, word(0, 4)));

      // Full stall on grant 2 after one beat.
      vecs.push_back(vr(4'h4, 1'b0));
      vecs.push_back(vr(4'h4, 1'b1));
      vecs.push_back(vn(4'h4, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 32'h0));
      vecs.push_back(vn(4'h4, 1'b0, 4'b0100, 1'b1, 1'b1, 2'd2, word(2, 0)));
      for (int s = 0; s < 3; s++)
         vecs.push_back(vn(4'h4, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd2, 32'h0));
      for (int k = 1; k < MB; k++)
         vecs.push_back(vn(4'h4, 1'b0, 4'b0100, 1'b1, 1'b1, 2'd2, word(2, k)));
      vecs.push_back(vn(4'h4, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 32'h0));
      vecs.push_back(vn(4'h4, 1'b0, 4'b0100, 1'b1, 1'b1, 2'd2, word(2, 4)));

      // Early release of grant 3; next grant wraps to 0.
      vecs.push_back(vr(4'h8, 1'b0));
      vecs.push_back(vr(4'h8, 1'b1));
      vecs.push_back(vn(4'h8, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 32'h0));
      vecs.push_back(vn(4'h8, 1'b0, 4'b1000, 1'b1, 1'b1, 2'd3, word(3, 0)));
      vecs.push_back(vn(4'h8, 1'b0, 4'b1000, 1'b1, 1'b1, 2'd3, word(3, 1)));
      vecs.push_back(vn(4'h3, 1'b0, 4'b1000, 1'b0, 1'b1, 2'd3, 32'h0));
      vecs.push_back(vn(4'h3, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 32'h0));
      vecs.push_back(vn(4'h3, 1'b0, 4'b0001, 1'b1, 1'b1, 2'd0, word(0, 0)));

      for (int i = 0; i < vecs.size(); i++) begin
         apply(vecs[i].rst_n, vecs[i].valid, vecs[i].full);
         check($sformatf("row%0d ready", i), 32'(u_if.req_ready), 32'(vecs[i].ready));
         check($sformatf("row%0d wr_en", i), 32'(u_if.fifo_wr_en), 32'(vecs[i].wr));
         check($sformatf("row%0d cs", i), 32'(u_if.fifo_cs), 32'(vecs[i].wr));
         if (vecs[i].ck_busy)
            check($sformatf("row%0d busy", i), 32'(u_if.busy), 32'(vecs[i].busy));
         if (vecs[i].rst_n && vecs[i].busy)
            check($sformatf("row%0d grant_id", i), 32'(u_if.grant_id), 32'(vecs[i].gid));
         if (vecs[i].rst_n && (vecs[i].wr || !vecs[i].busy))
            check($sformatf("row%0d data", i), u_if.fifo_data, vecs[i].data);
         advance();
      end

      // Single producer streaming 10 words: 4 W, idle, 4 W, idle, 2 W.
      apply(1'b0, 4'b0010, 1'b0); advance();
      apply(1'b0, 4'b0010, 1'b0); advance();
      pat  = 14'b01101111011110;
      nexp = 0;
      for (int c = 0; c < 14; c++) begin
         apply(1'b1, (seq[1] < 10) ? 4'b0010 : 4'b0000, 1'b0);
         check($sformatf("stream c%0d wr_en", c), 32'(u_if.fifo_wr_en), 32'(pat[c]));
         if (pat[c]) begin
            check($sformatf("stream word%0d", nexp), u_if.fifo_data, word(1, nexp));
            nexp++;
         end
         advance();
      end
      apply(1'b1, 4'b0000, 1'b0);
      check("stream end busy", 32'(u_if.busy), 32'd0);
      check("stream count", 32'(seq[1]), 32'd10);
      advance();

      // Reset during the third beat of grant 1.
      apply(1'b0, 4'b0010, 1'b0); advance();
      apply(1'b0, 4'b0010, 1'b0); advance();
      apply(1'b1, 4'b0010, 1'b0);
      check("midrst idle busy", 32'(u_if.busy), 32'd0);
      advance();
      for (int k = 0; k < 2; k++) begin
         apply(1'b1, 4'b0010, 1'b0);
         check($sformatf("midrst beat%0d wr_en", k), 32'(u_if.fifo_wr_en), 32'd1);
         check($sformatf("midrst beat%0d data", k), u_if.fifo_data, word(1, k));
         advance();
      end
      apply(1'b0, 4'b0011, 1'b0);
      check("midrst rst wr_en", 32'(u_if.fifo_wr_en), 32'd0);
      check("midrst rst cs", 32'(u_if.fifo_cs), 32'd0);
      check("midrst rst ready", 32'(u_if.req_ready), 32'd0);
      advance();
      apply(1'b1, 4'b0011, 1'b0);
      check("midrst after busy", 32'(u_if.busy), 32'd0);
      advance();
      apply(1'b1, 4'b0011, 1'b0);
      check("midrst regrant busy", 32'(u_if.busy), 32'd1);
      check("midrst regrant id", 32'(u_if.grant_id), 32'd0);
      check("midrst regrant wr_en", 32'(u_if.fifo_wr_en), 32'd1);
      check("midrst regrant data", u_if.fifo_data, word(0, 0));
      advance();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin write arbiter that shares one synchronous FIFO write port among NUM_REQ producers. Each producer uses a valid/ready handshake. The arbiter grants one producer at a time and holds the grant for a burst of up to MAX_BURST beats. It drives the FIFO's chip-select, write-enable and data inputs, and observes the FIFO's full flag. It sits directly in front of the team's synchronous FIFO, on its write side.

Parameters:
NUM_REQ, 4, number of producers (must be >= 2)
DATA_WIDTH, 32, data word width; must match the FIFO data width
MAX_BURST, 4, maximum beats per grant before the arbiter rotates (must be >= 1)

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  reset, synchronous, active-low
req_valid  input  NUM_REQ  per-producer valid
req_data  input  NUM_REQ*DATA_WIDTH  producer i word occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
req_ready  output  NUM_REQ  per-producer ready; at most one bit high (one-hot or zero)
fifo_full  input  1  full flag from the FIFO
fifo_cs  output  1  FIFO chip select
fifo_wr_en  output  1  FIFO write enable
fifo_data  output  DATA_WIDTH  FIFO write data
grant_id  output  ID_W  index of the current grantee; valid only while busy is high
busy  output  1  high in GRANT state

Behaviour:
- ID_W = max(1, $clog2(NUM_REQ)).
- Registered state: state (IDLE/GRANT), grant_id, last_id, beat_cnt. beat_cnt width is $clog2(MAX_BURST+1).
- Reset (rst_n low at a clock edge) forces:
  - state=IDLE, grant_id=0, last_id=NUM_REQ-1, beat_cnt=0.
  - Result: all req_ready=0, fifo_wr_en=0, fifo_cs=0, busy=0.
  - Reset wins over every other event.
  - Reset mid-burst drops the grant. No partial state survives. Words already written to the FIFO stay there, because the FIFO has its own reset.
- IDLE:
  - req_ready=0, fifo_wr_en=0.
  - If any req_valid is set, search indices last_id+1, last_id+2, ... modulo NUM_REQ, and pick the first one with req_valid=1.
  - On the next edge: grant_id=winner, beat_cnt=0, state=GRANT.
  - Arbitration costs exactly 1 idle cycle per grant.
- GRANT (g = grant_id):
  - Combinational outputs:
    - req_ready[g] = ~fifo_full; every other req_ready bit = 0.
    - xfer = req_valid[g] & ~fifo_full.
    - fifo_wr_en = fifo_cs = xfer.
    - fifo_data = req_data slice g. Drive this whenever in GRANT (it is don't-care when xfer=0). Drive 0 in IDLE.
  - The FIFO captures the word on the same edge as the handshake, so there is zero added latency.
  - On xfer: beat_cnt += 1.
  - Release the grant (next state=IDLE, last_id=g, beat_cnt=0) when either:
    - xfer occurs and beat_cnt == MAX_BURST-1 (burst exhausted), or
    - req_valid[g] == 0 (producer has gone idle).
  - fifo_full=1 with req_valid[g]=1 is a stall: hold the grant, do not change beat_cnt, do not release. There is no timeout.
- Fairness: a producer that stays continuously valid waits at most (NUM_REQ-1)*(MAX_BURST+1) cycles plus FIFO-full stall time.
- Requesters other than the grantee are ignored while in GRANT. Their req_valid may toggle freely.
- Producers must hold req_data stable while req_valid=1 and req_ready=0. The arbiter does not check this.
- The arbiter never asserts fifo_wr_en while fifo_full=1, so no overflow can originate here.

Decomposition:
- Shared package fifo_arb_pkg holds:
  - the state enum (ARB_IDLE, ARB_GRANT);
  - a function rr_next(valid, last_id) that returns the winner index plus a found bit.
- One natural sub-module: rr_pick. It is purely combinational: a rotate / priority-encode / un-rotate block over NUM_REQ. It is instantiated once in IDLE decode.
- The FIFO itself is not instantiated inside this block; the integrator connects it at the top level.

Test Plan:
- Reset value check: rst_n=0 for 2 cycles, all req_valid=1 -> req_ready=0, fifo_wr_en=0, busy=0. After rst_n=1: IDLE for 1 cycle, then grant_id=0, busy=1.
- Single producer, long stream: only req_valid[1]=1 for 10 words, MAX_BURST=4, fifo_full=0 -> 4 writes, 1 idle cycle, 4 writes, 1 idle cycle, 2 writes. fifo_data order matches the input order.
- Round-robin: all 4 producers continuously valid, MAX_BURST=4 -> grant sequence 0,1,2,3,0. Each grant gets exactly 4 consecutive fifo_wr_en pulses, separated by 1-cycle gaps.
- Full stall: grant 2, 1 beat done, then fifo_full=1 for 3 cycles -> req_ready[2]=0 and fifo_wr_en=0 for those 3 cycles, grant held, beat_cnt stays 1. After full clears, 3 more beats, then release.
- Early release: grant 3 sends 2 beats, then req_valid[3]=0 -> return to IDLE. The next grant goes to the lowest valid index after 3 (wrapping to 0).
- Reset mid-burst: rst_n=0 during the beat-2 cycle of grant 1 -> no fifo_wr_en that cycle. After reset, arbitration restarts from index 0.
